fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register. Owns the PC and drives the instruction-ROM request handshake.
//  Applies ID-stage branch redirects and pipeline-controller flushes, and delivers {addr, inst, delayslot flag} to ID.
//  Raises fetch_stall_req while an instruction fetch is outstanding.
// PARAMETERS
//  RESET_PC    32'hbfc0_0000   PC value after reset release
//  ADDR_WIDTH  32              PC / ROM address width
//  INST_WIDTH  32              instruction width
// PORTS
//  clk                       in   1   single clock; all state on posedge
//  rst                       in   1   asynchronous, active-low reset
//  stall_if                  in   1   hold PC; issue no new request
//  stall_id                  in   1   hold IF/ID register (ID not consuming)
//  flush                     in   1   exception/eret redirect, one-cycle pulse
//  exc_pc                    in   32  redirect target, valid with flush
//  branch_flag               in   1   ID branch taken
//  branch_addr               in   32  branch target
//  next_inst_delayslot_flag  in   1   ID: the instruction after the one in ID is a delay slot
//  rom_en                    out  1   fetch request
//  rom_addr                  out  32  fetch address; stable while rom_en=1 and rom_ready=0
//  rom_rdata                 in   32  fetch data, valid with rom_ready
//  rom_ready                 in   1   request accepted and data returned (>=0 wait cycles)
//  fetch_stall_req           out  1   request outstanding and no instruction available for ID
//  id_valid                  out  1   IF/ID holds a real instruction
//  id_addr                   out  32  PC of the instruction in ID
//  id_inst                   out  32  instruction in ID; 0 (nop) when !id_valid
//  id_delayslot_flag         out  1   instruction in ID is a delay slot
//  id_fetch_addr_err         out  1   (FETCH_ADDR_ERR_EN only) PC misaligned
// BEHAVIOUR
//  Reset (rst=0): pc=RESET_PC, state=RESET.
//   Reset values: rom_en=0, id_valid=0, id_inst=0, id_addr=0, id_delayslot_flag=0, skid empty, discard=0.
//  FSM states:
//   RESET -> FETCH on the first clock after reset release.
//   FETCH: rom_en=1, rom_addr=pc when !stall_if.
//    rom_ready=1 completes the fetch (zero-wait).
//    rom_ready=0 -> WAIT.
//   WAIT: rom_en=1, rom_addr held. rom_ready=1 -> FETCH.
//  Completion with stall_id=0: IF/ID <= {pc, rom_rdata, ds_pending}, id_valid=1.
//  Completion with stall_id=1: data goes to a 1-entry skid buffer.
//   No new request while the skid buffer is full.
//   The skid buffer drains into IF/ID on the first cycle stall_id=0.
//  PC update on completion: pc <= branch_flag ? branch_addr : pc+4. Addition wraps mod 2^32.
//  Branch redirect must not be lost:
//   If branch_flag arrives while WAIT, or while stall_if=1, latch the target.
//   Apply the latched target at the next PC update.
//  Delay slot: ds_pending <= next_inst_delayslot_flag, sampled whenever ID is not stalled.
//   ds_pending tags the next instruction loaded into IF/ID.
//  stall_id=1 freezes all id_* outputs.
//  stall_id=0 with no instruction available: id_valid=0, id_inst=0 (bubble).
//  Flush (priority over branch and stall):
//   next cycle: id_valid=0, id_inst=0; skid buffer cleared; ds_pending=0; latched branch cleared; pc=exc_pc.
//   Flush during WAIT: set discard and keep rom_addr stable until rom_ready.
//    Drop the returned data, clear discard, then fetch exc_pc.
//   Flush on the same cycle as rom_ready: drop the data; the next request uses exc_pc.
//  fetch_stall_req = (state==WAIT) | discard.
//  Reset mid-WAIT drops the request immediately (async). The ROM side must tolerate rom_en falling.
// CONFIGURATION
//  FETCH_ADDR_ERR_EN defined:
//   If pc[1:0]!=0, no ROM request is issued.
//   IF/ID loads {pc, 0, ds}, id_valid=1, id_fetch_addr_err=1. It flows like a nop so the exception unit raises AdEL.
//  FETCH_ADDR_ERR_EN undefined:
//   Port absent. pc[1:0] is forced to 0 on every PC load.
// STRUCTURE
//  Add to shared bus/defines header: RESET_PC, NOP_INST (32'h0), FSM state encodings FS_RESET/FS_FETCH/FS_WAIT.
//  Sub-module fetch_skid_buf: 1-entry {addr, inst, ds} buffer with full flag, load/drain/clear.
// TESTING
//  1. Reset release, rom_ready tied 1: rom_addr = bfc00000, bfc00004, bfc00008 on successive cycles.
//     id_addr follows one cycle later; id_valid=1 from cycle 2.
//  2. rom_ready delayed 3 cycles at bfc00004: rom_addr held 4 cycles, fetch_stall_req=1 for 3 cycles.
//     id_inst gets the data once.
//  3. ID at bfc00008 asserts branch_flag, branch_addr=bfc00100, next_inst_delayslot_flag:
//     bfc0000c enters ID with id_delayslot_flag=1; next fetch is bfc00100 with flag 0.
//  4. stall_id=1 for 2 cycles while a fetch completes:
//     id_* unchanged; skid buffer holds the instruction; no new rom_en.
//     After release: skid contents appear in ID, then in-order fetch resumes.
//  5. flush with exc_pc=bfc00380 during WAIT:
//     returned data dropped; next rom_addr=bfc00380; id_valid=0 until it lands.
//  6. FETCH_ADDR_ERR_EN, branch_addr=bfc00102:
//     rom_en=0 at that PC; id_fetch_addr_err=1, id_inst=0, id_addr=bfc00102.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared constants and types for the instruction fetch stage.
//   RESET_PC  : PC value after reset release
//   NOP_INST  : encoding used for bubbles in the IF/ID register
//   fetch_state_e : fetch FSM encodings FS_RESET / FS_FETCH / FS_WAIT
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_RESET = 2'd0,
    FS_FETCH = 2'd1,
    FS_WAIT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
//   One-entry {addr, inst, delay-slot} holding buffer. Captures a completed
//   fetch while ID is stalled so the ROM handshake never has to be replayed.
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   load                  capture in_* (sets full)
//   drain                 entry consumed by IF/ID (clears full)
//   clear                 drop the entry (flush); wins over load/drain
//   in_addr/in_inst/in_ds entry to capture
//   full                  entry valid
//   out_addr/out_inst/out_ds  stored entry
// ---------------------------------------------------------------------------
module fetch_skid_buf
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  drain,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [INST_WIDTH-1:0] in_inst,
  input  logic                  in_ds,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic                  out_ds
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  // Payload is only meaningful while full is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      out_addr <= in_addr;
      out_inst <= in_inst;
      out_ds   <= in_ds;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   IF stage plus IF/ID pipeline register. Owns the PC, drives the
//   instruction-ROM request handshake, applies branch redirects and flushes,
//   and presents {addr, inst, delay-slot flag} to ID.
//   Optional feature macro: FETCH_ADDR_ERR_EN (misaligned PC -> no ROM
//   request, instruction flagged on id_fetch_addr_err). Without it the PC is
//   force-aligned on every load and the port does not exist.
// Ports
//   clk, rst (async, active-low)
//   stall_if / stall_id       hold PC / hold IF/ID
//   flush, exc_pc             exception redirect
//   branch_flag, branch_addr  ID branch redirect
//   next_inst_delayslot_flag  next instruction into IF/ID is a delay slot
//   rom_en, rom_addr, rom_rdata, rom_ready   instruction ROM handshake
//   fetch_stall_req           fetch outstanding, nothing for ID
//   id_valid, id_addr, id_inst, id_delayslot_flag [, id_fetch_addr_err]
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(fetch_stage_pkg::RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_if,
  input  logic                  stall_id,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] exc_pc,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  input  logic                  next_inst_delayslot_flag,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [INST_WIDTH-1:0] rom_rdata,
  input  logic                  rom_ready,
  output logic                  fetch_stall_req,
  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_addr,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic                  id_delayslot_flag
`ifdef FETCH_ADDR_ERR_EN
  ,
  output logic                  id_fetch_addr_err
`endif
);

  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(NOP_INST);

  function automatic logic [ADDR_WIDTH-1:0] pc_align(input logic [ADDR_WIDTH-1:0] a);
`ifdef FETCH_ADDR_ERR_EN
    return a;
`else
    return {a[ADDR_WIDTH-1:2], 2'b00};
`endif
  endfunction

  fetch_state_e          state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] br_lat_addr;
  logic                  br_lat_vld;
  logic                  br_seen;
  logic                  discard;
  logic                  ds_pending;
  logic                  ds_cur;
  logic                  pc_misaligned;
  logic                  fetch_ok;
  logic                  rom_done;
  logic                  take_data;
  logic                  err_take;
  logic                  pc_upd;
  logic                  br_new;
  logic                  id_load;
  logic                  skid_load;
  logic                  skid_drain;
  logic                  skid_full;
  logic [ADDR_WIDTH-1:0] skid_addr;
  logic [INST_WIDTH-1:0] skid_inst;
  logic                  skid_ds;

`ifdef FETCH_ADDR_ERR_EN
  assign pc_misaligned = (pc[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  // A new request is allowed only from FETCH, with IF not stalled and the
  // skid entry free (it must drain before anything else is fetched).
  assign fetch_ok  = (state == FS_FETCH) && !stall_if && !skid_full;
  assign rom_done  = rom_en && rom_ready;
  assign take_data = rom_done && !discard && !flush;
  assign err_take  = fetch_ok && pc_misaligned && !stall_id && !flush;
  assign pc_upd    = take_data || err_take;

  // br_seen marks that the branch of the instruction held in a stalled ID
  // has already been used, so a held branch_flag is applied only once.
  assign br_new  = branch_flag && !br_seen;
  assign pc_next = br_new     ? pc_align(branch_addr) :
                   br_lat_vld ? br_lat_addr :
                                pc_align(rom_addr + ADDR_WIDTH'(4));

  // A delay-slot mark from ID sticks until an instruction is actually loaded.
  assign ds_cur = ds_pending || next_inst_delayslot_flag;

  assign id_load    = !stall_id && !flush && (skid_full || take_data || err_take);
  assign skid_load  = stall_id && take_data;
  assign skid_drain = !stall_id && !flush && skid_full;

  // --- IF: fetch FSM ---
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FS_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FS_RESET: state_nxt = FS_FETCH;
      FS_FETCH: if (rom_en && !rom_ready) state_nxt = FS_WAIT;
      FS_WAIT:  if (rom_ready) state_nxt = FS_FETCH;
      default:  state_nxt = FS_RESET;
    endcase
  end

  always_comb begin
    rom_en          = (state == FS_WAIT) || (fetch_ok && !pc_misaligned);
    rom_addr        = (state == FS_WAIT) ? req_addr : pc;
    fetch_stall_req = (state == FS_WAIT) || discard;
  end

  // --- IF: PC, redirect and delay-slot control ---
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= pc_align(RESET_PC);
      discard    <= 1'b0;
      br_lat_vld <= 1'b0;
      br_seen    <= 1'b0;
      ds_pending <= 1'b0;
    end else begin
      if (flush) begin
        pc <= pc_align(exc_pc);
      end else if (pc_upd) begin
        pc <= pc_next;
      end

      // An outstanding request hit by a flush still has to complete on the
      // bus; its data is thrown away when it arrives.
      if (rom_done) begin
        discard <= 1'b0;
      end else if (flush && rom_en) begin
        discard <= 1'b1;
      end

      if (flush || pc_upd) begin
        br_lat_vld <= 1'b0;
      end else if (br_new) begin
        br_lat_vld <= 1'b1;
      end

      br_seen <= !flush && stall_id && (br_seen || branch_flag);

      if (flush || id_load || skid_load) begin
        ds_pending <= 1'b0;
      end else if (!stall_id) begin
        ds_pending <= ds_cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == FS_FETCH) && rom_en) begin
      req_addr <= pc;
    end
    if (br_new && !flush && !pc_upd) begin
      br_lat_addr <= pc_align(branch_addr);
    end
  end

  fetch_skid_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .drain    (skid_drain),
    .clear    (flush),
    .in_addr  (rom_addr),
    .in_inst  (rom_rdata),
    .in_ds    (ds_cur),
    .full     (skid_full),
    .out_addr (skid_addr),
    .out_inst (skid_inst),
    .out_ds   (skid_ds)
  );

  // --- IF/ID register ---
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid          <= 1'b0;
      id_addr           <= '0;
      id_inst           <= NOP;
      id_delayslot_flag <= 1'b0;
    end else if (flush) begin
      id_valid          <= 1'b0;
      id_inst           <= NOP;
      id_delayslot_flag <= 1'b0;
    end else if (!stall_id) begin
      if (skid_full) begin
        id_valid          <= 1'b1;
        id_addr           <= skid_addr;
        id_inst           <= skid_inst;
        id_delayslot_flag <= skid_ds;
      end else if (take_data) begin
        id_valid          <= 1'b1;
        id_addr           <= rom_addr;
        id_inst           <= rom_rdata;
        id_delayslot_flag <= ds_cur;
      end else if (err_take) begin
        id_valid          <= 1'b1;
        id_addr           <= pc;
        id_inst           <= NOP;
        id_delayslot_flag <= ds_cur;
      end else begin
        id_valid          <= 1'b0;
        id_inst           <= NOP;
        id_delayslot_flag <= 1'b0;
      end
    end
  end

`ifdef FETCH_ADDR_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_fetch_addr_err <= 1'b0;
    end else if (flush) begin
      id_fetch_addr_err <= 1'b0;
    end else if (!stall_id) begin
      id_fetch_addr_err <= !skid_full && !take_data && err_take;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. The ROM model returns addr + 0x10000000,
//   so every expected instruction word is derivable by hand from its address.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, stall_id, flush, branch_flag, next_inst_delayslot_flag;
  logic [31:0] exc_pc, branch_addr;
  logic        rom_en, rom_ready, fetch_stall_req;
  logic [31:0] rom_addr, rom_rdata;
  logic        id_valid, id_delayslot_flag;
  logic [31:0] id_addr, id_inst;
`ifdef FETCH_ADDR_ERR_EN
  logic        id_fetch_addr_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rom_rdata = rom_addr + 32'h1000_0000;

  fetch_stage dut (
    .clk                      (clk),
    .rst                      (rst),
    .stall_if                 (stall_if),
    .stall_id                 (stall_id),
    .flush                    (flush),
    .exc_pc                   (exc_pc),
    .branch_flag              (branch_flag),
    .branch_addr              (branch_addr),
    .next_inst_delayslot_flag (next_inst_delayslot_flag),
    .rom_en                   (rom_en),
    .rom_addr                 (rom_addr),
    .rom_rdata                (rom_rdata),
    .rom_ready                (rom_ready),
    .fetch_stall_req          (fetch_stall_req),
    .id_valid                 (id_valid),
    .id_addr                  (id_addr),
    .id_inst                  (id_inst),
    .id_delayslot_flag        (id_delayslot_flag)
`ifdef FETCH_ADDR_ERR_EN
    ,
    .id_fetch_addr_err        (id_fetch_addr_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_if = 1'b0; stall_id = 1'b0; flush = 1'b0; exc_pc = '0;
    branch_flag = 1'b0; branch_addr = '0; next_inst_delayslot_flag = 1'b0;
    rom_ready = 1'b1;
  endtask

  // Returns one cycle after release, with the FSM in FETCH at RESET_PC.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    clear_inputs();
    #2;
    check("rst_rom_en", rom_en, 0);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_inst", id_inst, 0);
    check("rst_id_addr", id_addr, 0);
    check("rst_id_ds", id_delayslot_flag, 0);
    check("rst_stall_req", fetch_stall_req, 0);
    cyc();
    check("rst_hold_rom_en", rom_en, 0);

    // Sequential zero-wait fetch
    do_reset(); #1;
    check("t1_rom_en", rom_en, 1);
    check("t1_addr0", rom_addr, 32'hbfc0_0000);
    check("t1_id_valid0", id_valid, 0);
    cyc(); #1;
    check("t1_addr1", rom_addr, 32'hbfc0_0004);
    check("t1_id_valid1", id_valid, 1);
    check("t1_id_addr1", id_addr, 32'hbfc0_0000);
    check("t1_id_inst1", id_inst, 32'hcfc0_0000);
    cyc(); #1;
    check("t1_addr2", rom_addr, 32'hbfc0_0008);
    check("t1_id_addr2", id_addr, 32'hbfc0_0004);
    cyc(); #1;
    check("t1_id_addr3", id_addr, 32'hbfc0_0008);
    check("t1_id_inst3", id_inst, 32'hcfc0_0008);

    // Three wait cycles at bfc00004
    do_reset(); #1;
    cyc(); rom_ready = 1'b0; #1;
    check("t2_addr_a", rom_addr, 32'hbfc0_0004);
    check("t2_stall_a", fetch_stall_req, 0);
    cyc(); #1;
    check("t2_addr_b", rom_addr, 32'hbfc0_0004);
    check("t2_stall_b", fetch_stall_req, 1);
    check("t2_bubble_b", id_valid, 0);
    cyc(); #1;
    check("t2_addr_c", rom_addr, 32'hbfc0_0004);
    check("t2_stall_c", fetch_stall_req, 1);
    cyc(); rom_ready = 1'b1; #1;
    check("t2_addr_d", rom_addr, 32'hbfc0_0004);
    check("t2_stall_d", fetch_stall_req, 1);
    check("t2_rom_en_d", rom_en, 1);
    cyc(); #1;
    check("t2_addr_e", rom_addr, 32'hbfc0_0008);
    check("t2_stall_e", fetch_stall_req, 0);
    check("t2_id_valid_e", id_valid, 1);
    check("t2_id_addr_e", id_addr, 32'hbfc0_0004);
    check("t2_id_inst_e", id_inst, 32'hcfc0_0004);
    cyc(); #1;
    check("t2_id_inst_f", id_inst, 32'hcfc0_0008);

    // Branch in ID at bfc00008 with delay slot
    do_reset();
    repeat (3) cyc();
    branch_flag = 1'b1; branch_addr = 32'hbfc0_0100; next_inst_delayslot_flag = 1'b1;
    cyc();
    branch_flag = 1'b0; next_inst_delayslot_flag = 1'b0; #1;
    check("t3_ds_addr", id_addr, 32'hbfc0_000c);
    check("t3_ds_flag", id_delayslot_flag, 1);
    check("t3_target", rom_addr, 32'hbfc0_0100);
    cyc(); #1;
    check("t3_tgt_id_addr", id_addr, 32'hbfc0_0100);
    check("t3_tgt_id_inst", id_inst, 32'hcfc0_0100);
    check("t3_tgt_ds", id_delayslot_flag, 0);
    check("t3_seq", rom_addr, 32'hbfc0_0104);

    // ID stalled for two cycles while bfc00004 completes
    do_reset();
    cyc(); stall_id = 1'b1; #1;
    check("t4_addr_a", rom_addr, 32'hbfc0_0004);
    cyc(); #1;
    check("t4_hold_addr_b", id_addr, 32'hbfc0_0000);
    check("t4_hold_inst_b", id_inst, 32'hcfc0_0000);
    check("t4_no_req_b", rom_en, 0);
    cyc(); #1;
    check("t4_hold_addr_c", id_addr, 32'hbfc0_0000);
    check("t4_no_req_c", rom_en, 0);
    stall_id = 1'b0; #1;
    check("t4_no_req_drain", rom_en, 0);
    cyc(); #1;
    check("t4_skid_addr", id_addr, 32'hbfc0_0004);
    check("t4_skid_inst", id_inst, 32'hcfc0_0004);
    check("t4_resume", rom_addr, 32'hbfc0_0008);
    check("t4_resume_en", rom_en, 1);
    cyc(); #1;
    check("t4_next_addr", id_addr, 32'hbfc0_0008);

    // Flush to bfc00380 while bfc00004 is outstanding
    do_reset();
    cyc(); rom_ready = 1'b0;
    cyc(); flush = 1'b1; exc_pc = 32'hbfc0_0380;
    cyc(); flush = 1'b0; #1;
    check("t5_held_addr", rom_addr, 32'hbfc0_0004);
    check("t5_stall", fetch_stall_req, 1);
    check("t5_bubble_a", id_valid, 0);
    rom_ready = 1'b1;
    cyc(); #1;
    check("t5_exc_addr", rom_addr, 32'hbfc0_0380);
    check("t5_stall_clr", fetch_stall_req, 0);
    check("t5_dropped", id_valid, 0);
    check("t5_dropped_inst", id_inst, 0);
    cyc(); #1;
    check("t5_land_valid", id_valid, 1);
    check("t5_land_addr", id_addr, 32'hbfc0_0380);
    check("t5_land_inst", id_inst, 32'hcfc0_0380);

    // Branch arriving during WAIT is latched and applied at completion
    do_reset();
    cyc(); rom_ready = 1'b0;
    cyc(); branch_flag = 1'b1; branch_addr = 32'hbfc0_0200;
    cyc(); branch_flag = 1'b0; rom_ready = 1'b1; #1;
    check("t7_held", rom_addr, 32'hbfc0_0004);
    cyc(); #1;
    check("t7_target", rom_addr, 32'hbfc0_0200);
    check("t7_id_addr", id_addr, 32'hbfc0_0004);
    cyc(); #1;
    check("t7_tgt_id", id_addr, 32'hbfc0_0200);

    // IF stall holds the PC with no request
    do_reset(); stall_if = 1'b1; #1;
    check("t8_no_req", rom_en, 0);
    cyc(); #1;
    check("t8_no_req2", rom_en, 0);
    check("t8_bubble", id_valid, 0);
    stall_if = 1'b0; #1;
    check("t8_pc_held", rom_addr, 32'hbfc0_0000);

    // Misaligned branch target bfc00102
    do_reset(); branch_flag = 1'b1; branch_addr = 32'hbfc0_0102;
    cyc(); branch_flag = 1'b0; #1;
`ifdef FETCH_ADDR_ERR_EN
    check("t6_no_req", rom_en, 0);
    cyc(); #1;
    check("t6_err", id_fetch_addr_err, 1);
    check("t6_valid", id_valid, 1);
    check("t6_inst", id_inst, 0);
    check("t6_addr", id_addr, 32'hbfc0_0102);
`else
    check("t6_req", rom_en, 1);
    check("t6_aligned", rom_addr, 32'hbfc0_0100);
    cyc(); #1;
    check("t6_id_addr", id_addr, 32'hbfc0_0100);
    check("t6_id_inst", id_inst, 32'hcfc0_0100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
